// File: rtl/chip8_fetch_decode.sv
// CHIP-8 fetch/decode stage: owns the PC, fetches each opcode as two bytes
// (high byte first) and presents registered decode fields over valid/ready.
module chip8_fetch_decode #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] START_PC = 'h200,
  parameter int                MEM_LAT  = 1,
  parameter bit                SCHIP    = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_en,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  input  logic              skip,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [15:0]       opcode,
  output logic [ADDR_W-1:0] pc_out,
  output logic [3:0]        op_main,
  output logic [4:0]        op_sub,
  output logic [3:0]        x,
  output logic [3:0]        y,
  output logic [3:0]        n,
  output logic [7:0]        nn,
  output logic [11:0]       nnn,
  output logic [2:0]        alu_op,
  output logic              alu_switchxy,
  output logic              illegal
);

  // state     | meaning
  // S_IDLE    | waiting for fetch_en
  // S_RD_HI   | mem_rd asserted for the high byte at PC
  // S_WAIT_HI | waiting MEM_LAT cycles, high byte captured on terminal count
  // S_RD_LO   | mem_rd asserted for the low byte at PC+1
  // S_WAIT_LO | low byte captured, then one cycle to register the decode
  // S_VALID   | dec_valid=1, outputs held until dec_ready
  typedef enum logic [2:0] {
    S_IDLE, S_RD_HI, S_WAIT_HI, S_RD_LO, S_WAIT_LO, S_VALID
  } state_t;

  localparam logic [2:0] LAT_HI = 3'(MEM_LAT - 1);
  localparam logic [2:0] LAT_LO = 3'(MEM_LAT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, mem_addr_q, mem_addr_d, pc_out_q, pc_out_d;
  logic [2:0]        cnt_q, cnt_d, alu_op_q, alu_op_d, dec_alu;
  logic [7:0]        hi_q, hi_d, lo_q, lo_d;
  logic [15:0]       opcode_q, opcode_d, raw;
  logic [4:0]        op_sub_q, op_sub_d, dec_sub;
  logic              mem_rd_q, mem_rd_d, dec_valid_q, dec_valid_d;
  logic              alu_sw_q, alu_sw_d, illegal_q, illegal_d;
  logic              dec_sw, dec_ill, handshake;

  assign raw       = {hi_q, lo_q};
  assign handshake = (state_q == S_VALID) && dec_ready;

  always_comb begin
    dec_sub = 5'd0;
    dec_alu = 3'd0;
    dec_sw  = 1'b0;
    dec_ill = 1'b0;
    case (raw[15:12])
      4'h0: begin
        case (raw[7:0])
          8'hE0: dec_sub = 5'd1;
          8'hEE: dec_sub = 5'd2;
          8'hFB: if (SCHIP) dec_sub = 5'd15; else dec_ill = 1'b1;
          8'hFC: if (SCHIP) dec_sub = 5'd16; else dec_ill = 1'b1;
          8'hFD: if (SCHIP) dec_sub = 5'd17; else dec_ill = 1'b1;
          8'hFE: if (SCHIP) dec_sub = 5'd18; else dec_ill = 1'b1;
          8'hFF: if (SCHIP) dec_sub = 5'd19; else dec_ill = 1'b1;
          default: begin
            if (SCHIP && raw[7:4] == 4'hC) dec_sub = 5'd14;
            else dec_ill = 1'b1;
          end
        endcase
      end
      4'h5, 4'h9: dec_ill = (raw[3:0] != 4'h0);
      4'h8: begin
        case (raw[3:0])
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: dec_alu = raw[2:0];
          4'h7: begin
            dec_alu = 3'd5;
            dec_sw  = 1'b1;
          end
          4'hE:    dec_alu = 3'd7;
          default: dec_ill = 1'b1;
        endcase
      end
      4'hE: begin
        case (raw[7:0])
          8'h9E:   dec_sub = 5'd3;
          8'hA1:   dec_sub = 5'd4;
          default: dec_ill = 1'b1;
        endcase
      end
      4'hF: begin
        case (raw[7:0])
          8'h07: dec_sub = 5'd5;
          8'h0A: dec_sub = 5'd6;
          8'h15: dec_sub = 5'd7;
          8'h18: dec_sub = 5'd8;
          8'h1E: dec_sub = 5'd9;
          8'h29: dec_sub = 5'd10;
          8'h33: dec_sub = 5'd11;
          8'h55: dec_sub = 5'd12;
          8'h65: dec_sub = 5'd13;
          8'h30: if (SCHIP) dec_sub = 5'd20; else dec_ill = 1'b1;
          8'h75: if (SCHIP) dec_sub = 5'd21; else dec_ill = 1'b1;
          8'h85: if (SCHIP) dec_sub = 5'd22; else dec_ill = 1'b1;
          default: dec_ill = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    mem_rd_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    dec_valid_d = dec_valid_q;
    opcode_d    = opcode_q;
    pc_out_d    = pc_out_q;
    op_sub_d    = op_sub_q;
    alu_op_d    = alu_op_q;
    alu_sw_d    = alu_sw_q;
    illegal_d   = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (fetch_en) begin
          state_d    = S_RD_HI;
          mem_rd_d   = 1'b1;
          mem_addr_d = pc_q;
        end
      end
      S_RD_HI: begin
        state_d = S_WAIT_HI;
        cnt_d   = LAT_HI;
      end
      S_WAIT_HI: begin
        if (cnt_q == 3'd0) begin
          hi_d       = mem_data;
          state_d    = S_RD_LO;
          mem_rd_d   = 1'b1;
          mem_addr_d = pc_q + ADDR_W'(1);
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RD_LO: begin
        state_d = S_WAIT_LO;
        cnt_d   = LAT_LO;
      end
      S_WAIT_LO: begin
        if (cnt_q == 3'd0) begin
          state_d     = S_VALID;
          dec_valid_d = 1'b1;
          opcode_d    = raw;
          pc_out_d    = pc_q;
          op_sub_d    = dec_sub;
          alu_op_d    = dec_alu;
          alu_sw_d    = dec_sw;
          illegal_d   = dec_ill;
        end else begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) lo_d = mem_data;
        end
      end
      S_VALID: begin
        if (dec_ready) begin
          dec_valid_d = 1'b0;
          if (pc_load)   pc_d = pc_load_val;
          else if (skip) pc_d = pc_q + ADDR_W'(4);
          else           pc_d = pc_q + ADDR_W'(2);
          if (fetch_en) begin
            state_d    = S_RD_HI;
            mem_rd_d   = 1'b1;
            mem_addr_d = pc_d;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Redirect outside a handshake restarts the fetch; any byte in flight is dropped.
    if (pc_load && !handshake) begin
      pc_d        = pc_load_val;
      state_d     = S_RD_HI;
      mem_rd_d    = 1'b1;
      mem_addr_d  = pc_load_val;
      dec_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      pc_q        <= START_PC;
      cnt_q       <= 3'd0;
      hi_q        <= 8'd0;
      lo_q        <= 8'd0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= START_PC;
      dec_valid_q <= 1'b0;
      opcode_q    <= 16'd0;
      pc_out_q    <= '0;
      op_sub_q    <= 5'd0;
      alu_op_q    <= 3'd0;
      alu_sw_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      dec_valid_q <= dec_valid_d;
      opcode_q    <= opcode_d;
      pc_out_q    <= pc_out_d;
      op_sub_q    <= op_sub_d;
      alu_op_q    <= alu_op_d;
      alu_sw_q    <= alu_sw_d;
      illegal_q   <= illegal_d;
    end
  end

  assign mem_rd       = mem_rd_q;
  assign mem_addr     = mem_addr_q;
  assign dec_valid    = dec_valid_q;
  assign opcode       = opcode_q;
  assign pc_out       = pc_out_q;
  assign op_main      = opcode_q[15:12];
  assign op_sub       = op_sub_q;
  assign x            = opcode_q[11:8];
  assign y            = opcode_q[7:4];
  assign n            = opcode_q[3:0];
  assign nn           = opcode_q[7:0];
  assign nnn          = opcode_q[11:0];
  assign alu_op       = alu_op_q;
  assign alu_switchxy = alu_sw_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_chip8_fetch_decode.sv
// Bench for chip8_fetch_decode: DUT 0 (MEM_LAT=1, base set), DUT 1 (MEM_LAT=3,
// SUPER-CHIP). Expected decodes/reads are queued and popped by a negedge monitor.
module tb_chip8_fetch_decode;

  typedef struct packed {
    logic [15:0] op;
    logic [11:0] pc;
    logic [4:0]  sub;
    logic [2:0]  alu;
    logic        sw;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n [2];
  logic        fetch_en [2];
  logic        pc_load [2];
  logic        skip [2];
  logic        dec_ready [2];
  logic [11:0] pc_load_val [2];
  logic        mem_rd [2];
  logic [11:0] mem_addr [2];
  logic [7:0]  mem_data [2];
  logic        dec_valid [2];
  logic [15:0] opcode [2];
  logic [11:0] pc_out [2];
  logic [3:0]  op_main [2];
  logic [4:0]  op_sub [2];
  logic [3:0]  x [2];
  logic [3:0]  y [2];
  logic [3:0]  n [2];
  logic [7:0]  nn [2];
  logic [11:0] nnn [2];
  logic [2:0]  alu_op [2];
  logic        alu_switchxy [2];
  logic        illegal [2];

  logic [7:0]  mem [0:4095];
  logic        rdp0;
  logic [11:0] ap0;
  logic        rdp1 [3];
  logic [11:0] ap1 [3];

  int   checks = 0;
  int   failures = 0;
  exp_t exp0_q[$];
  exp_t exp1_q[$];
  logic [11:0] rd0_q[$];
  logic [11:0] rd1_q[$];
  exp_t cur [2];
  bit   have [2];

  always #5 clk = ~clk;

  chip8_fetch_decode #(.ADDR_W(12), .START_PC(12'h200), .MEM_LAT(1), .SCHIP(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n[0]), .fetch_en(fetch_en[0]), .mem_rd(mem_rd[0]),
    .mem_addr(mem_addr[0]), .mem_data(mem_data[0]), .pc_load(pc_load[0]),
    .pc_load_val(pc_load_val[0]), .skip(skip[0]), .dec_valid(dec_valid[0]),
    .dec_ready(dec_ready[0]), .opcode(opcode[0]), .pc_out(pc_out[0]), .op_main(op_main[0]),
    .op_sub(op_sub[0]), .x(x[0]), .y(y[0]), .n(n[0]), .nn(nn[0]), .nnn(nnn[0]),
    .alu_op(alu_op[0]), .alu_switchxy(alu_switchxy[0]), .illegal(illegal[0]));

  chip8_fetch_decode #(.ADDR_W(12), .START_PC(12'h400), .MEM_LAT(3), .SCHIP(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n[1]), .fetch_en(fetch_en[1]), .mem_rd(mem_rd[1]),
    .mem_addr(mem_addr[1]), .mem_data(mem_data[1]), .pc_load(pc_load[1]),
    .pc_load_val(pc_load_val[1]), .skip(skip[1]), .dec_valid(dec_valid[1]),
    .dec_ready(dec_ready[1]), .opcode(opcode[1]), .pc_out(pc_out[1]), .op_main(op_main[1]),
    .op_sub(op_sub[1]), .x(x[1]), .y(y[1]), .n(n[1]), .nn(nn[1]), .nnn(nnn[1]),
    .alu_op(alu_op[1]), .alu_switchxy(alu_switchxy[1]), .illegal(illegal[1]));

  // Memory read pipelines; unrelated cycles return a junk byte.
  always @(posedge clk) begin
    rdp0    <= mem_rd[0];
    ap0     <= mem_addr[0];
    rdp1[0] <= mem_rd[1];
    ap1[0]  <= mem_addr[1];
    rdp1[1] <= rdp1[0];
    ap1[1]  <= ap1[0];
    rdp1[2] <= rdp1[1];
    ap1[2]  <= ap1[1];
  end
  assign mem_data[0] = rdp0    ? mem[ap0]    : 8'hA5;
  assign mem_data[1] = rdp1[2] ? mem[ap1[2]] : 8'hA5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_dec(input int d);
    exp_t e;
    e = cur[d];
    chk($sformatf("dut%0d_opcode@%0h", d, e.pc), 32'(opcode[d]), 32'(e.op));
    chk($sformatf("dut%0d_pc_out@%0h", d, e.pc), 32'(pc_out[d]), 32'(e.pc));
    chk($sformatf("dut%0d_fields@%0h", d, e.pc),
        {op_main[d], x[d], y[d], n[d], nn[d], 8'h00},
        {e.op[15:12], e.op[11:8], e.op[7:4], e.op[3:0], e.op[7:0], 8'h00});
    chk($sformatf("dut%0d_nnn@%0h", d, e.pc), 32'(nnn[d]), 32'(e.op[11:0]));
    chk($sformatf("dut%0d_op_sub@%0h", d, e.pc), 32'(op_sub[d]), 32'(e.sub));
    chk($sformatf("dut%0d_alu@%0h", d, e.pc), 32'({alu_op[d], alu_switchxy[d]}), 32'({e.alu, e.sw}));
    chk($sformatf("dut%0d_illegal@%0h", d, e.pc), 32'(illegal[d]), 32'(e.ill));
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (dec_valid[d] === 1'b1) begin
        if (!have[d]) begin
          if ((d == 0 && exp0_q.size() == 0) || (d == 1 && exp1_q.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL dut%0d_unexpected_valid actual=%h@%h expected=none", d, opcode[d], pc_out[d]);
          end else begin
            if (d == 0) cur[d] = exp0_q.pop_front();
            else        cur[d] = exp1_q.pop_front();
            have[d] = 1'b1;
            check_dec(d);
          end
        end else begin
          chk($sformatf("dut%0d_stable_opcode", d), 32'(opcode[d]), 32'(cur[d].op));
          chk($sformatf("dut%0d_stable_pc", d), 32'(pc_out[d]), 32'(cur[d].pc));
        end
        if (dec_ready[d] === 1'b1) have[d] = 1'b0;
      end else begin
        have[d] = 1'b0;
      end
      if (mem_rd[d] === 1'b1) begin
        logic [11:0] a;
        if ((d == 0 && rd0_q.size() == 0) || (d == 1 && rd1_q.size() == 0)) begin
          checks++;
          failures++;
          $display("FAIL dut%0d_unexpected_read actual=%h expected=none", d, mem_addr[d]);
        end else begin
          if (d == 0) a = rd0_q.pop_front();
          else        a = rd1_q.pop_front();
          chk($sformatf("dut%0d_rd_addr", d), 32'(mem_addr[d]), 32'(a));
        end
      end
    end
  end

  task automatic wait_valid(input int d, output int c);
    c = 0;
    while (dec_valid[d] !== 1'b1 && c < 60) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (dec_valid[d] !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL dut%0d_valid_timeout actual=0 expected=1", d);
    end
  endtask

  task automatic hs(input int d, input int stall, input logic sk, input logic ld,
                    input logic [11:0] lv, input logic fe);
    int c;
    wait_valid(d, c);
    repeat (stall) @(posedge clk);
    #1;
    dec_ready[d]   = 1'b1;
    skip[d]        = sk;
    pc_load[d]     = ld;
    pc_load_val[d] = lv;
    fetch_en[d]    = fe;
    @(posedge clk);
    #1;
    dec_ready[d] = 1'b0;
    skip[d]      = 1'b0;
    pc_load[d]   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int c;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    {mem['h200], mem['h201]} = 16'h00E0;
    {mem['h202], mem['h203]} = 16'h8347;
    {mem['h204], mem['h205]} = 16'h1234;
    {mem['h206], mem['h207]} = 16'h6666;
    {mem['h208], mem['h209]} = 16'h00FF;
    {mem['h20A], mem['h20B]} = 16'h8ABF;
    {mem['h20C], mem['h20D]} = 16'h5121;
    {mem['h20E], mem['h20F]} = 16'hF233;
    {mem['h210], mem['h211]} = 16'h6ABC;
    {mem['h300], mem['h301]} = 16'hD120;
    mem['hFFF] = 8'hA1;
    mem['h000] = 8'h23;
    mem['h001] = 8'hE5;
    mem['h002] = 8'h9E;
    {mem['h400], mem['h401]} = 16'h00FF;
    {mem['h402], mem['h403]} = 16'hF285;
    {mem['h404], mem['h405]} = 16'h00C5;
    for (int d = 0; d < 2; d++) begin
      reset_n[d] = 1'b0; fetch_en[d] = 1'b0; pc_load[d] = 1'b0;
      skip[d] = 1'b0; dec_ready[d] = 1'b0; pc_load_val[d] = 12'h000;
    end

    // DUT 0 stimulus and expectations
    exp0_q.push_back('{16'h00E0, 12'h200, 5'd1,  3'd0, 1'b0, 1'b0});
    exp0_q.push_back('{16'h8347, 12'h202, 5'd0,  3'd5, 1'b1, 1'b0});
    exp0_q.push_back('{16'h1234, 12'h204, 5'd0,  3'd0, 1'b0, 1'b0});
    exp0_q.push_back('{16'h00FF, 12'h208, 5'd0,  3'd0, 1'b0, 1'b1});
    exp0_q.push_back('{16'h8ABF, 12'h20A, 5'd0,  3'd0, 1'b0, 1'b1});
    exp0_q.push_back('{16'h5121, 12'h20C, 5'd0,  3'd0, 1'b0, 1'b1});
    exp0_q.push_back('{16'hF233, 12'h20E, 5'd11, 3'd0, 1'b0, 1'b0});
    exp0_q.push_back('{16'hD120, 12'h300, 5'd0,  3'd0, 1'b0, 1'b0});
    exp0_q.push_back('{16'hA123, 12'hFFF, 5'd0,  3'd0, 1'b0, 1'b0});
    exp0_q.push_back('{16'hE59E, 12'h001, 5'd3,  3'd0, 1'b0, 1'b0});
    rd0_q = '{12'h200, 12'h201, 12'h202, 12'h203, 12'h204, 12'h205, 12'h208, 12'h209,
              12'h20A, 12'h20B, 12'h20C, 12'h20D, 12'h20E, 12'h20F, 12'h210, 12'h211,
              12'h300, 12'h301, 12'hFFF, 12'h000, 12'h001, 12'h002};

    repeat (3) @(posedge clk);
    #1;
    chk("dut0_rst_valid", 32'(dec_valid[0]), 32'h0);
    chk("dut0_rst_mem_rd", 32'(mem_rd[0]), 32'h0);
    chk("dut0_rst_mem_addr", 32'(mem_addr[0]), 32'h200);
    chk("dut0_rst_illegal", 32'(illegal[0]), 32'h0);
    chk("dut0_rst_decode", {opcode[0], 11'd0, op_sub[0]}, 32'h0);
    reset_n[0] = 1'b1;
    @(posedge clk);
    #1;
    fetch_en[0] = 1'b1;
    wait_valid(0, c);
    chk("dut0_latency", 32'(c - 1), 32'd5);
    hs(0, 0, 1'b0, 1'b0, 12'h000, 1'b1);
    hs(0, 3, 1'b0, 1'b0, 12'h000, 1'b1);
    hs(0, 0, 1'b1, 1'b0, 12'h000, 1'b1);
    hs(0, 0, 1'b0, 1'b0, 12'h000, 1'b1);
    hs(0, 1, 1'b0, 1'b0, 12'h000, 1'b1);
    hs(0, 0, 1'b0, 1'b0, 12'h000, 1'b1);
    hs(0, 0, 1'b0, 1'b0, 12'h000, 1'b1);
    // Redirect while the low byte of 0x210 is in flight.
    repeat (3) @(posedge clk);
    #1;
    pc_load[0] = 1'b1;
    pc_load_val[0] = 12'h300;
    @(posedge clk);
    #1;
    pc_load[0] = 1'b0;
    hs(0, 0, 1'b0, 1'b1, 12'hFFF, 1'b1);
    hs(0, 0, 1'b0, 1'b0, 12'h000, 1'b1);
    hs(0, 0, 1'b0, 1'b0, 12'h000, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    chk("dut0_idle_valid", 32'(dec_valid[0]), 32'h0);
    chk("dut0_exp_left", 32'(exp0_q.size()), 32'd0);
    chk("dut0_rd_left", 32'(rd0_q.size()), 32'd0);

    // DUT 1: SUPER-CHIP decode, MEM_LAT=3, reset in the middle of a fetch
    exp1_q.push_back('{16'h00FF, 12'h400, 5'd19, 3'd0, 1'b0, 1'b0});
    exp1_q.push_back('{16'hF285, 12'h402, 5'd22, 3'd0, 1'b0, 1'b0});
    exp1_q.push_back('{16'h00FF, 12'h400, 5'd19, 3'd0, 1'b0, 1'b0});
    rd1_q = '{12'h400, 12'h401, 12'h402, 12'h403, 12'h404, 12'h400, 12'h401};
    reset_n[1] = 1'b1;
    @(posedge clk);
    #1;
    fetch_en[1] = 1'b1;
    wait_valid(1, c);
    chk("dut1_latency", 32'(c - 1), 32'd9);
    hs(1, 0, 1'b0, 1'b0, 12'h000, 1'b1);
    hs(1, 0, 1'b0, 1'b0, 12'h000, 1'b1);
    @(posedge clk);
    #1;
    reset_n[1]  = 1'b0;
    fetch_en[1] = 1'b0;
    @(posedge clk);
    #1;
    reset_n[1] = 1'b1;
    chk("dut1_rst_mem_addr", 32'(mem_addr[1]), 32'h400);
    chk("dut1_rst_mem_rd", 32'(mem_rd[1]), 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("dut1_post_rst_valid_%0d", i), 32'({dec_valid[1], mem_rd[1]}), 32'h0);
    end
    fetch_en[1] = 1'b1;
    hs(1, 0, 1'b0, 1'b0, 12'h000, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    chk("dut1_exp_left", 32'(exp1_q.size()), 32'd0);
    chk("dut1_rd_left", 32'(rd1_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
